// File: rtl/uart_pkg.sv
// Shared definitions for the UART command receiver: default bit period and
// the receiver state encoding.
package uart_pkg;

  // 50 MHz system clock / 19200 baud
  localparam int BAUD_DIV_DEFAULT = 2604;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/cmd_fifo2.sv
// Two-entry byte FIFO. The head entry is always mem0, so dout is a plain register.
// A pop and a push in the same cycle are applied as pop-then-push.
module cmd_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  logic [7:0] mem0;
  logic [7:0] mem1;
  logic [1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0  <= 8'h00;
      mem1  <= 8'h00;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          // a pop on an empty FIFO is ignored
          if (push) begin
            mem0  <= din;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            mem0 <= din;
          end else if (push) begin
            mem1  <= din;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          // a push without a pop is dropped; the caller flags the overrun
          if (pop) begin
            mem0 <= mem1;
            if (push) mem1 <= din;
            else      count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  assign dout  = mem0;
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for BLE command bytes with a 2-entry receive buffer.
// Handshake: rdy is high while a byte is buffered; a one-cycle clr_rdy pops the head (ignored when empty).
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rdy,
  input  logic       clr_rdy,
  output logic       frm_err,
  output logic       ovr_err,
  input  logic       clr_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          push;
  logic          tc;
  logic          empty;
  logic          full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // the counter runs down from its load value; the last count marks mid-bit
  assign tc = (baud_cnt <= CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      push     <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      push <= 1'b0;
      if (clr_err) frm_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            baud_cnt <= HALF_BIT;
            state    <= START;
          end
        end
        START: begin
          if (tc) begin
            if (!rx_s) begin
              baud_cnt <= FULL_BIT;
              bit_cnt  <= 4'd0;
              state    <= DATA;
            end else begin
              baud_cnt <= '0;
              state    <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        DATA: begin
          if (tc) begin
            shreg    <= {rx_s, shreg[7:1]};
            baud_cnt <= FULL_BIT;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        STOP: begin
          if (tc) begin
            baud_cnt <= '0;
            if (rx_s) begin
              push  <= 1'b1;
              state <= IDLE;
            end else begin
              // written after the clear above, so a new error beats clr_err
              frm_err <= 1'b1;
              state   <= WAIT_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_err <= 1'b0;
    end else begin
      if (clr_err) ovr_err <= 1'b0;
      if (push && full && !clr_rdy) ovr_err <= 1'b1;
    end
  end

  cmd_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (clr_rdy),
    .din   (shreg),
    .dout  (rx_data),
    .empty (empty),
    .full  (full)
  );

  assign rdy = !empty;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: a fast instance for most scenarios plus one instance
// at the default 19200-baud divider for bit-timing and false-start checks.
module tb_uart_cmd_rx;
  import uart_pkg::*;

  localparam int BD      = 32;
  localparam int BD_SLOW = BAUD_DIV_DEFAULT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_slow = 1'b1;
  logic       clr_rdy = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, frm_err, ovr_err;
  logic [7:0] rx_data_slow;
  logic       rdy_slow, frm_err_slow, ovr_err_slow;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_cmd_rx #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .RX(rx), .rx_data(rx_data), .rdy(rdy),
    .clr_rdy(clr_rdy), .frm_err(frm_err), .ovr_err(ovr_err), .clr_err(clr_err)
  );

  uart_cmd_rx dut_slow (
    .clk(clk), .rst(rst), .RX(rx_slow), .rx_data(rx_data_slow), .rdy(rdy_slow),
    .clr_rdy(1'b0), .frm_err(frm_err_slow), .ovr_err(ovr_err_slow), .clr_err(1'b0)
  );

  // ---------------- driver tasks ----------------
  task automatic hold(input logic v, input int n, input bit slow);
    if (slow) rx_slow = v;
    else      rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit slow, input logic stop_val,
                            input int stop_bits);
    int bd;
    bd = slow ? BD_SLOW : BD;
    hold(1'b0, bd, slow);
    for (int i = 0; i < 8; i++) hold(b[i], bd, slow);
    hold(stop_val, stop_bits * bd, slow);
    if (!stop_val) hold(1'b1, bd, slow);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 1);
  endtask

  task automatic pop();
    clr_rdy = 1'b1;
    @(posedge clk);
    #1 clr_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_push(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 * BD; i++) begin
      @(negedge clk);
      if (dut.push) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy got %b exp 0", rdy); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h exp 00", rx_data); end
    vectors++; if (frm_err !== 1'b0) begin miscompares++; $display("FAIL reset_frm got %b exp 0", frm_err); end
    vectors++; if (ovr_err !== 1'b0) begin miscompares++; $display("FAIL reset_ovr got %b exp 0", ovr_err); end
    vectors++; if (rdy_slow !== 1'b0) begin miscompares++; $display("FAIL reset_rdy_slow got %b exp 0", rdy_slow); end
  endtask

  task automatic test_false_start_slow();
    hold(1'b0, 500, 1'b1);
    hold(1'b1, 2000, 1'b1);
    @(negedge clk);
    vectors++; if (rdy_slow !== 1'b0) begin miscompares++; $display("FAIL false_start_rdy got %b exp 0", rdy_slow); end
    vectors++; if (frm_err_slow !== 1'b0 || ovr_err_slow !== 1'b0) begin
      miscompares++; $display("FAIL false_start_flags got %b%b exp 00", frm_err_slow, ovr_err_slow);
    end
    vectors++; if (dut_slow.state !== IDLE) begin
      miscompares++; $display("FAIL false_start_state got %0d exp %0d", dut_slow.state, IDLE);
    end
  endtask

  task automatic test_default_baud();
    int cycles;
    cycles = 0;
    fork
      send_frame(8'h47, 1'b1, 1'b1, 1);
      begin
        while (!rdy_slow && cycles < 12 * BD_SLOW) begin
          @(negedge clk);
          cycles++;
        end
      end
    join
    vectors++; if (cycles < 9 * BD_SLOW || cycles > 10 * BD_SLOW) begin
      miscompares++; $display("FAIL slow_latency got %0d cycles exp %0d..%0d", cycles, 9 * BD_SLOW, 10 * BD_SLOW);
    end
    vectors++; if (rx_data_slow !== 8'h47) begin miscompares++; $display("FAIL slow_data got %h exp 47", rx_data_slow); end
    vectors++; if (frm_err_slow !== 1'b0 || ovr_err_slow !== 1'b0) begin
      miscompares++; $display("FAIL slow_flags got %b%b exp 00", frm_err_slow, ovr_err_slow);
    end
  endtask

  task automatic test_frame_error();
    bit seen;
    send_frame(8'h5A, 1'b0, 1'b0, 2);
    @(negedge clk);
    vectors++; if (frm_err !== 1'b1) begin miscompares++; $display("FAIL frm_set got %b exp 1", frm_err); end
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL frm_no_push got %b exp 0", rdy); end
    send(8'h53);
    @(negedge clk);
    vectors++; if (rdy !== 1'b1 || rx_data !== 8'h53) begin
      miscompares++; $display("FAIL frm_next got rdy=%b data=%h exp rdy=1 data=53", rdy, rx_data);
    end
    vectors++; if (frm_err !== 1'b1) begin miscompares++; $display("FAIL frm_sticky got %b exp 1", frm_err); end
    pop();
    clear_errors();
    vectors++; if (frm_err !== 1'b0) begin miscompares++; $display("FAIL frm_clear got %b exp 0", frm_err); end
    // clr_err held through a bad frame: the flag must still show for a cycle
    seen = 1'b0;
    fork
      begin
        clr_err = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 2);
        clr_err = 1'b0;
      end
      begin
        repeat (12 * BD) begin
          @(negedge clk);
          if (frm_err) seen = 1'b1;
        end
      end
    join
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL frm_set_wins got %b exp 1", seen); end
    clear_errors();
  endtask

  task automatic test_overflow();
    send(8'h47);
    send(8'h53);
    send(8'hA5);
    @(negedge clk);
    vectors++; if (ovr_err !== 1'b1) begin miscompares++; $display("FAIL ovr_set got %b exp 1", ovr_err); end
    vectors++; if (rx_data !== 8'h47) begin miscompares++; $display("FAIL ovr_head0 got %h exp 47", rx_data); end
    pop();
    vectors++; if (rdy !== 1'b1 || rx_data !== 8'h53) begin
      miscompares++; $display("FAIL ovr_head1 got rdy=%b data=%h exp rdy=1 data=53", rdy, rx_data);
    end
    pop();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL ovr_empty got %b exp 0", rdy); end
    pop();
    send(8'h3C);
    @(negedge clk);
    vectors++; if (rdy !== 1'b1 || rx_data !== 8'h3C) begin
      miscompares++; $display("FAIL underflow_next got rdy=%b data=%h exp rdy=1 data=3c", rdy, rx_data);
    end
    pop();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL underflow_empty got %b exp 0", rdy); end
    clear_errors();
  endtask

  task automatic test_pop_push_full();
    bit ok;
    send(8'h47);
    send(8'h53);
    fork
      send(8'hA5);
      begin
        wait_push(ok);
        if (ok) begin
          clr_rdy = 1'b1;
          @(posedge clk);
          #1 clr_rdy = 1'b0;
        end
      end
    join
    @(negedge clk);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL full_push_seen got %b exp 1", ok); end
    vectors++; if (ovr_err !== 1'b0) begin miscompares++; $display("FAIL full_popush_ovr got %b exp 0", ovr_err); end
    vectors++; if (rx_data !== 8'h53) begin miscompares++; $display("FAIL full_popush_head got %h exp 53", rx_data); end
    pop();
    vectors++; if (rdy !== 1'b1 || rx_data !== 8'hA5) begin
      miscompares++; $display("FAIL full_popush_tail got rdy=%b data=%h exp rdy=1 data=a5", rdy, rx_data);
    end
    fork
      send(8'h3C);
      begin
        wait_push(ok);
        if (ok) begin
          clr_rdy = 1'b1;
          @(posedge clk);
          #1 clr_rdy = 1'b0;
        end
      end
    join
    @(negedge clk);
    vectors++; if (rdy !== 1'b1 || rx_data !== 8'h3C) begin
      miscompares++; $display("FAIL one_popush got rdy=%b data=%h exp rdy=1 data=3c", rdy, rx_data);
    end
    pop();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL one_popush_empty got %b exp 0", rdy); end
  endtask

  task automatic test_reset_midframe();
    send(8'h53);
    fork
      send(8'hFF);
      begin
        repeat (5 * BD + BD / 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++; if (rdy !== 1'b0 || rx_data !== 8'h00) begin
          miscompares++; $display("FAIL midrst_outputs got rdy=%b data=%h exp rdy=0 data=00", rdy, rx_data);
        end
      end
    join
    hold(1'b1, 2 * BD, 1'b0);
    @(negedge clk);
    vectors++; if (rdy !== 1'b0 || frm_err !== 1'b0) begin
      miscompares++; $display("FAIL midrst_no_push got rdy=%b frm=%b exp 0 0", rdy, frm_err);
    end
    send(8'h47);
    @(negedge clk);
    vectors++; if (rdy !== 1'b1 || rx_data !== 8'h47) begin
      miscompares++; $display("FAIL midrst_next got rdy=%b data=%h exp rdy=1 data=47", rdy, rx_data);
    end
    pop();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       exp_ovr;
    int         n;
    for (int it = 0; it < 12; it++) begin
      exp_ovr = 1'b0;
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        hold(1'b0, $urandom_range(1, BD / 2 - 4), 1'b0);
        hold(1'b1, BD, 1'b0);
      end
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        if (exp_q.size() < 2) exp_q.push_back(b);
        else                  exp_ovr = 1'b1;
        send(b);
        if ($urandom_range(0, 1) == 1) hold(1'b1, $urandom_range(1, 2 * BD), 1'b0);
      end
      @(negedge clk);
      vectors++; if (ovr_err !== exp_ovr) begin
        miscompares++; $display("FAIL rand_ovr it=%0d got %b exp %b", it, ovr_err, exp_ovr);
      end
      vectors++; if (frm_err !== 1'b0) begin
        miscompares++; $display("FAIL rand_frm it=%0d got %b exp 0", it, frm_err);
      end
      while (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        vectors++; if (rdy !== 1'b1 || rx_data !== b) begin
          miscompares++; $display("FAIL rand_data it=%0d got rdy=%b data=%h exp rdy=1 data=%h", it, rdy, rx_data, b);
        end
        pop();
      end
      vectors++; if (rdy !== 1'b0) begin
        miscompares++; $display("FAIL rand_empty it=%0d got %b exp 0", it, rdy);
      end
      clear_errors();
    end
  endtask

  initial begin
    test_reset();
    test_false_start_slow();
    test_default_baud();
    test_frame_error();
    test_overflow();
    test_pop_push_full();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, meaning clocks per bit (50 MHz / 19200 baud).
REQ-002 SHALL have port clk  input  1  system clock; the block uses this single clock only.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port RX  input  1  asynchronous serial line from the BLE module; idle high; 8N1 format, LSB first.
REQ-005 SHALL have port rx_data  output  8  byte at the head of the receive buffer.
REQ-006 SHALL have port rdy  output  1  high while the buffer is not empty.
REQ-007 SHALL have port clr_rdy  input  1  one-cycle pulse that pops the head byte.
REQ-008 SHALL have port frm_err  output  1  sticky flag: a stop bit was sampled low.
REQ-009 SHALL have port ovr_err  output  1  sticky flag: a byte was dropped because the buffer was full.
REQ-010 SHALL have port clr_err  input  1  one-cycle pulse that clears frm_err and ovr_err.

Function
REQ-011 SHALL pass RX through a two-flop synchronizer; both flops are preset to 1 on reset; only the synchronized value is used downstream.
REQ-012 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 SHALL move from IDLE to START when synchronized RX is 0, loading the baud counter with BAUD_DIV/2 (integer divide).
REQ-014 SHALL, in START at baud-counter terminal count, go to DATA if RX is still 0; otherwise it SHALL return to IDLE (false start), with no flag set and no push.
REQ-015 SHALL, in DATA, reload the counter with BAUD_DIV at each bit and sample RX at terminal count (mid-bit); it SHALL shift the sample into bit 7 and shift right, taking 8 samples counted by a 4-bit counter.
REQ-016 SHALL, in STOP, sample RX at mid-bit; if 1, it SHALL push the byte and go to IDLE.
REQ-017 SHALL, if the stop bit is 0, set frm_err, discard the byte and go to WAIT_IDLE; it SHALL leave WAIT_IDLE only when synchronized RX is 1 (a break condition does not retrigger).
REQ-018 SHALL buffer received bytes in a 2-entry FIFO; rdy and rx_data SHALL update on the clock edge after the stop-bit sample (1-cycle latency).
REQ-019 SHALL ignore clr_rdy while the FIFO is empty; it SHALL NOT underflow.
REQ-020 SHALL, on a push while the FIFO is full with no simultaneous pop, drop the new byte, set ovr_err and keep the existing contents.
REQ-021 SHALL, on a push and clr_rdy in the same cycle while full, pop then push, with no ovr_err.
REQ-022 SHALL, on a push and clr_rdy in the same cycle while holding one entry, keep occupancy at 1 with the new byte at the head.
REQ-023 SHALL, on clr_err in the same cycle as a new error event, leave the flag set (set wins).
REQ-024 SHALL hold rx_data stable while rdy is high and clr_rdy is not pulsed.

Reset
REQ-025 SHALL, on rst high at a clk edge, force: state IDLE; FIFO empty; rdy=0; rx_data=8'h00; frm_err=0; ovr_err=0; all counters 0; synchronizer flops 1.
REQ-026 SHALL, on reset mid-frame, abandon the partial byte and not push it; the next complete frame after reset SHALL be received normally.

Structure
REQ-027 SHALL take its state enum and the default BAUD_DIV constant from the shared task_pkg-style design package (uart_pkg); it SHALL NOT define them locally.
REQ-028 SHALL implement the 2-entry FIFO as one sub-module, cmd_fifo2: push, pop, din[7:0], dout[7:0], empty, full, with the same clk/rst.

Verification
REQ-029 SHALL verify: UART_tx sends 8'h47 ('G') at BAUD_DIV=2604 -> rdy rises about 9.5 bit times after the start edge, rx_data=8'h47, no flags set.
REQ-030 SHALL verify: RX driven low for 500 clocks, then high -> no rdy, no flags, state returns to IDLE.
REQ-031 SHALL verify: frame 8'h5A sent with the stop bit forced low for 2 bit times -> frm_err=1, rdy=0; the following 8'h53 is received correctly.
REQ-032 SHALL verify: 8'h47, 8'h53, 8'hA5 sent back-to-back with no clr_rdy -> ovr_err=1; pops yield 8'h47 then 8'h53, then rdy=0.
REQ-033 SHALL verify: clr_rdy pulsed in the same cycle as the third push with the FIFO full -> no ovr_err; the FIFO holds 8'h53, 8'hA5.
REQ-034 SHALL verify: rst asserted for 1 cycle at data bit 4 of 8'hFF -> all outputs reset, no push; the next 8'h47 is received correctly.
